pdm_rx_frontend: RTL
====================

PDM_RX_FRONTEND -- requirements
Module: pdm_rx_frontend

Interface
REQ-001 The block SHALL have parameter NUM_PINS, default 2, giving the number of PDM data pins; CH = 2*NUM_PINS logical channels.
REQ-002 The block SHALL have parameter DIV_W, default 8, giving the clock-divider config width; CH_W = max(1, clog2(CH)).
REQ-003 The block SHALL have port clk_i  in  1  system clock; the block has one clock.
REQ-004 The block SHALL have port rstn_i  in  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port cfg_en_i  in  1  run enable.
REQ-006 The block SHALL have port cfg_update_i  in  1  one-cycle pulse that latches the config and restarts the block.
REQ-007 The block SHALL have port cfg_clk_div_i  in  DIV_W  half-period of the PDM clock, minus 1.
REQ-008 The block SHALL have port cfg_ch_mask_i  in  CH  per-channel enable.
REQ-009 The block SHALL have port cfg_dual_edge_i  in  1  selects dual-edge mode: 1 = two channels per pin, 0 = even channels only.
REQ-010 The block SHALL have port pdm_data_i  in  NUM_PINS  PDM data pins.
REQ-011 The block SHALL have port pdm_clk_o  out  1  PDM clock to the microphones.
REQ-012 The block SHALL have port bit_data_o  out  1  PDM bit to the decimator.
REQ-013 The block SHALL have port bit_ch_o  out  CH_W  channel index of bit_data_o.
REQ-014 The block SHALL have port bit_valid_o  out  1  bit_data_o and bit_ch_o are valid.
REQ-015 The block SHALL have port bit_ready_i  in  1  decimator accepts the bit.
REQ-016 The block SHALL have port overrun_o  out  1  sticky overrun flag.
REQ-017 The block SHALL have port clr_overrun_i  in  1  one-cycle pulse that clears overrun_o.

Function
REQ-018 Shadow registers for div, mask and dual_edge SHALL load from cfg_* only in a cycle where cfg_update_i=1; all other logic SHALL use only the shadow values.
REQ-019 The half-period counter SHALL count 0..div; on the cycle it equals div, it SHALL wrap to 0 and pdm_clk_o SHALL toggle; pdm_clk_o period = 2*(div+1) clk_i cycles (div=0 gives clk_i/2).
REQ-020 The end of the high phase is the cycle with counter==div and pdm_clk_o=1; in that cycle, pdm_data_i[p] SHALL be captured into slot 2p.
REQ-021 The end of the low phase is the cycle with counter==div and pdm_clk_o=0; in that cycle, pdm_data_i[p] SHALL be captured into slot 2p+1 if dual_edge=1.
REQ-022 The end of the low phase SHALL also be the frame end.
REQ-023 At frame end, the output buffer SHALL be loaded with the slots, including the odd slots captured in that same cycle.
REQ-024 At frame end, pending SHALL be loaded with mask & (dual_edge ? all-ones : even-only).
REQ-025 The first frame after a restart SHALL be emitted at the first low-phase end that follows at least one high-phase end; before that, no frame SHALL be emitted.
REQ-026 The sequencer SHALL present the lowest-index pending channel on bit_ch_o, with bit_data_o = buffer[bit_ch_o], and bit_valid_o = (pending != 0).
REQ-027 On a cycle with bit_valid_o & bit_ready_i, the sequencer SHALL clear the presented pending bit; the next pending channel SHALL appear in the following cycle, giving throughput of 1 bit per cycle.
REQ-028 While bit_valid_o=1 and bit_ready_i=0, bit_data_o and bit_ch_o SHALL remain stable.
REQ-029 Overrun: if a frame end occurs while pending, after removing the bit handshaked in that same cycle, is nonzero, the new frame SHALL replace buffer and pending, and overrun_o SHALL be set to 1.
REQ-030 overrun_o SHALL clear on clr_overrun_i or cfg_update_i; if a set and a clear occur in the same cycle, set SHALL win.
REQ-031 mask=0 SHALL produce no output while the PDM clock keeps running.
REQ-032 With cfg_en_i=0: the counter SHALL be held at 0, pdm_clk_o SHALL be held at 0, and no captures or frame ends SHALL occur; already pending bits SHALL continue to drain.
REQ-033 On a 0->1 transition of cfg_en_i, the block SHALL behave as a restart.
REQ-034 A cfg_update_i pulse SHALL: clear the counter, pdm_clk_o, pending and overrun_o; the first edge SHALL follow div+1 cycles later, using the new config.
REQ-035 cfg_update_i SHALL take priority over every frame end and handshake in the same cycle.
REQ-036 Block latency SHALL be: bit_valid_o rises exactly 1 cycle after the frame-end cycle.

Reset
REQ-037 When rstn_i=0 at a clk_i edge, the block SHALL set pdm_clk_o=0, bit_valid_o=0, bit_data_o=0, bit_ch_o=0, overrun_o=0, counter=0, pending=0, buffer=0, slots=0.
REQ-038 The same reset SHALL set the shadow registers to div=0, mask=0 and dual_edge=0.
REQ-039 A reset asserted in the middle of a frame SHALL discard the pending bits without emitting them.
REQ-040 After reset is released, there SHALL be no PDM activity on the outputs until cfg_update_i is pulsed with a nonzero mask.

Verification
REQ-041 Scenario: NUM_PINS=2; div=1, mask=4'b1111, dual=1, ready=1; pin0 high in high phase / low in low phase, pin1 inverted -> pdm_clk_o period 4 cycles; each frame emits ch0=1, ch1=0, ch2=0, ch3=1 on 4 consecutive cycles starting 1 cycle after the frame end.
REQ-042 Scenario: dual=0, mask=4'b1111 -> only ch0 and ch2 are emitted per frame; ch1 and ch3 never appear.
REQ-043 Scenario: div=1, mask=4'b1111, ready held 0 for 5 cycles -> data and channel stay stable; overrun_o=1 at the next frame end; clr_overrun_i -> overrun_o=0 on the next cycle; simultaneous clr_overrun_i and overrun event -> overrun_o=1.
REQ-044 Scenario: mask=4'b0101 with ready toggling 1,0,1 -> ch0 is accepted, ch2 is held for 1 cycle and then accepted; bit_valid_o=0 afterwards until the next frame.
REQ-045 Scenario: cfg_update_i pulsed mid-frame with div changed 1->3 -> pending is cleared, pdm_clk_o=0, the first rising edge occurs 4 cycles later, and the period becomes 8 cycles.
REQ-046 Scenario: rstn_i=0 for 1 cycle while 3 bits are pending -> all outputs are 0 on the next cycle; no bits are emitted until cfg_update_i is pulsed.

Source files
------------

// File: rtl/pdm_rx_frontend.sv
// pdm_rx_frontend
//   Generates the PDM microphone clock, samples NUM_PINS data pins on both
//   phases (two channels per pin in dual-edge mode), and serialises each
//   frame of captured bits to a decimator over a valid/ready handshake.
//
// Ports
//   clk_i, rstn_i     system clock, synchronous active-low reset
//   cfg_en_i          run enable (0->1 restarts the block)
//   cfg_update_i      pulse: latch cfg_* into shadow registers and restart
//   cfg_clk_div_i     PDM clock half-period minus 1
//   cfg_ch_mask_i     per-channel enable
//   cfg_dual_edge_i   1 = two channels per pin, 0 = even channels only
//   pdm_data_i        PDM data pins
//   pdm_clk_o         PDM clock to the microphones
//   bit_data_o/bit_ch_o/bit_valid_o/bit_ready_i   serial bit stream
//   overrun_o         sticky: a frame arrived before the previous one drained
//   clr_overrun_i     pulse: clear overrun_o
module pdm_rx_frontend #(
   parameter  int NUM_PINS = 2,
   parameter  int DIV_W    = 8,
   localparam int CH       = 2 * NUM_PINS,
   localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                cfg_en_i,
   input  logic                cfg_update_i,
   input  logic [DIV_W-1:0]    cfg_clk_div_i,
   input  logic [CH-1:0]       cfg_ch_mask_i,
   input  logic                cfg_dual_edge_i,
   input  logic [NUM_PINS-1:0] pdm_data_i,
   output logic                pdm_clk_o,
   output logic                bit_data_o,
   output logic [CH_W-1:0]     bit_ch_o,
   output logic                bit_valid_o,
   input  logic                bit_ready_i,
   output logic                overrun_o,
   input  logic                clr_overrun_i
);

   // shadow configuration
   logic [DIV_W-1:0] div_q;
   logic [CH-1:0]    mask_q;
   logic             dual_q;
   // run_q: set once a non-empty mask has been configured since reset
   logic             run_q;
   logic             en_q;

   logic [DIV_W-1:0] cnt_q;
   logic             pdm_clk_q;
   // armed_q: a high-phase end has been seen since the last restart
   logic             armed_q;
   logic [CH-1:0]    slots_q;
   logic [CH-1:0]    buffer_q;
   logic [CH-1:0]    pending_q;
   logic             overrun_q;

   logic             restart;
   logic             running;
   logic             tick;
   logic             high_end;
   logic             low_end;
   logic             frame_end;
   logic             hs;
   logic [CH-1:0]    slots_nxt;
   logic [CH-1:0]    pend_after;
   logic [CH-1:0]    frame_mask;
   logic [CH_W-1:0]  ch_sel;

   always_comb begin
      restart   = cfg_update_i | (cfg_en_i & ~en_q);
      running   = cfg_en_i & en_q & run_q;
      tick      = running & (cnt_q == div_q);
      high_end  = tick & pdm_clk_q;
      low_end   = tick & ~pdm_clk_q;
      frame_end = low_end & armed_q;

      // odd slots captured at the frame end go straight into the buffer
      slots_nxt = slots_q;
      for (int unsigned p = 0; p < NUM_PINS; p++) begin
         if (high_end)           slots_nxt[2*p]   = pdm_data_i[p];
         if (low_end && dual_q)  slots_nxt[2*p+1] = pdm_data_i[p];
      end

      // descending scan so the last hit is the lowest pending index
      ch_sel = '0;
      for (int unsigned i = CH; i > 0; i--) begin
         if (pending_q[i-1]) ch_sel = CH_W'(i - 1);
      end

      hs         = (|pending_q) & bit_ready_i;
      pend_after = pending_q;
      if (hs) pend_after[ch_sel] = 1'b0;

      for (int unsigned i = 0; i < CH; i++) begin
         frame_mask[i] = mask_q[i] & (dual_q | (i % 2 == 0));
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         div_q     <= '0;
         mask_q    <= '0;
         dual_q    <= 1'b0;
         run_q     <= 1'b0;
         en_q      <= 1'b0;
         cnt_q     <= '0;
         pdm_clk_q <= 1'b0;
         armed_q   <= 1'b0;
         slots_q   <= '0;
         buffer_q  <= '0;
         pending_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         en_q <= cfg_en_i;
         if (cfg_update_i) begin
            div_q  <= cfg_clk_div_i;
            mask_q <= cfg_ch_mask_i;
            dual_q <= cfg_dual_edge_i;
            run_q  <= run_q | (|cfg_ch_mask_i);
         end
         if (restart) begin
            cnt_q     <= '0;
            pdm_clk_q <= 1'b0;
            armed_q   <= 1'b0;
            pending_q <= '0;
            overrun_q <= 1'b0;
         end else begin
            if (!running) begin
               cnt_q     <= '0;
               pdm_clk_q <= 1'b0;
            end else if (tick) begin
               cnt_q     <= '0;
               pdm_clk_q <= ~pdm_clk_q;
            end else begin
               cnt_q <= cnt_q + DIV_W'(1);
            end
            slots_q <= slots_nxt;
            if (high_end) armed_q <= 1'b1;
            if (frame_end) begin
               buffer_q  <= slots_nxt;
               pending_q <= frame_mask;
            end else begin
               pending_q <= pend_after;
            end
            // set wins over a simultaneous clear
            if (frame_end && (|pend_after)) overrun_q <= 1'b1;
            else if (clr_overrun_i)         overrun_q <= 1'b0;
         end
      end
   end

   assign pdm_clk_o   = pdm_clk_q;
   assign bit_valid_o = |pending_q;
   assign bit_ch_o    = ch_sel;
   assign bit_data_o  = buffer_q[ch_sel];
   assign overrun_o   = overrun_q;

endmodule
